spi_arb: RTL and testbench
==========================

SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning frame length in bits (range 2..32).
REQ-002 SHALL have parameter DIV_POW, default 1, meaning SCLK half-period H = 2^DIV_POW CLK_IN cycles (range 0..7).
REQ-003 SHALL have port CLK_IN  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_IN  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  1 = new frames may be granted.
REQ-006 SHALL have ports req0, req1  input  1 each  requester n holds high while it has a word pending.
REQ-007 SHALL have ports data0, data1  input  DATA_W each  requester n's word, MSB first.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  one-cycle pulse: requester n's word was captured.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port CS  output  1  chip select, active low.
REQ-012 SHALL have port SCLK  output  1  serial clock, idle low (SPI mode 0).
REQ-013 SHALL have port SDO  output  1  serial data out.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, GAP; all outputs registered.
REQ-015 In IDLE with enable=1 and any req high, the arbitration edge SHALL set gnt_n=1 for the winner only, load the shift register with data_n, drive SDO=data_n[DATA_W-1], drive CS=0, and enter SETUP.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the winner is the requester not granted last; after reset requester 0 wins first.
REQ-017 With a single requester high, that requester SHALL win regardless of history.
REQ-018 data_n SHALL be sampled only on the grant edge; later changes to it SHALL NOT affect the frame in flight.
REQ-019 A req dropped before its grant SHALL produce no frame; a req still high after gnt SHALL be treated as a new word.
REQ-020 SETUP SHALL last H cycles with CS=0, SCLK=0, and SDO holding the MSB.
REQ-021 SHIFT SHALL last 2*DATA_W*H cycles and toggle SCLK every H cycles, starting with a rise, for DATA_W rising edges in total.
REQ-022 On each SCLK falling edge except the last, SDO SHALL advance to the next lower bit; SDO SHALL be stable across every rising edge.
REQ-023 HOLD SHALL last H cycles with CS=0 and SCLK=0.
REQ-024 GAP SHALL last H cycles with CS=1, after which the FSM returns to IDLE.
REQ-025 done SHALL pulse in the first GAP cycle.
REQ-026 CS low time SHALL be exactly (2*DATA_W+2)*H cycles.
REQ-027 Minimum CS-high time between back-to-back frames SHALL be H+1 cycles.
REQ-028 The divider counter SHALL be DIV_POW+1 bits wide and reload to H-1 at every state change and SCLK toggle.
REQ-029 With DIV_POW=0, SCLK SHALL toggle every cycle.
REQ-030 The bit counter SHALL be width clog2(DATA_W+1) and SHALL NOT wrap inside a frame.
REQ-031 enable deasserting mid-frame SHALL NOT abort the frame; it only blocks the next grant.
REQ-032 SDO SHALL be 0 in IDLE and GAP.

Reset
REQ-033 RST_IN=1 at a rising edge SHALL, at that same edge, force state=IDLE, CS=1, SCLK=0, SDO=0, gnt0=gnt1=0, busy=0, done=0, and round-robin pointer to "requester 0 next", aborting any frame in flight without a done pulse.
REQ-034 The first grant SHALL be possible on the first edge after RST_IN falls.

Verification (DATA_W=16, DIV_POW=1, H=2)
REQ-035 Single frame: req0=1, data0=16'hA5C3 -> gnt0 pulses at the same edge CS falls; 16 SCLK rises sample SDO=1010010111000011; CS low 68 cycles; done pulses once.
REQ-036 Contention: req0=req1=1 held from reset -> grants alternate 0,1,0,1, and each CS-high gap is 3 cycles.
REQ-037 Enable gating: enable=0 with req1=1 -> no gnt and CS stays 1; enable rises -> gnt1 on the next edge; enable dropped mid-frame -> frame still 68 cycles and no further grant.
REQ-038 Data change: data0 changed to 16'h0000 one cycle after gnt0 -> serialized bits remain 16'hA5C3.
REQ-039 Reset mid-frame: RST_IN=1 at SCLK rise 7 -> next cycle CS=1, SCLK=0, SDO=0, busy=0, no done; then req0=req1=1 -> gnt0 first.
REQ-040 DIV_POW=0: single frame -> CS low exactly 34 cycles, and SCLK toggles every cycle during SHIFT.

Source files
------------

// File: rtl/spi_arb.sv
// Two-requester round-robin arbiter feeding a single SPI mode-0 transmitter.
// A granted word is framed as SETUP -> SHIFT -> HOLD -> GAP, all outputs registered.
module spi_arb #(
  parameter int DATA_W  = 16,
  parameter int DIV_POW = 1
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              enable,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              CS,
  output logic              SCLK,
  output logic              SDO
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int DIV_W = DIV_POW + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'((1 << DIV_POW) - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  // Bits still to be sent below the one currently on SDO, left-aligned.
  logic [DATA_W-2:0] shreg;
  logic              rr_next;   // 1: requester 1 wins a tie next
  logic              tick;
  logic              grant_any;
  logic              win1;
  logic [DATA_W-1:0] sel_data;

  assign tick      = (div_cnt == '0);
  assign grant_any = (state == ST_IDLE) && enable && (req0 || req1);

  // Arbitration: tie goes to rr_next, otherwise the lone requester wins.
  always_comb begin
    win1     = (req0 && req1) ? rr_next : req1;
    sel_data = win1 ? data1 : data0;
  end

  // Next-state: each timed state ends when the divider expires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_any) state_nxt = ST_SETUP;
      ST_SETUP: if (tick) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && !SCLK && (bit_cnt == BIT_LAST)) state_nxt = ST_HOLD;
      ST_HOLD:  if (tick) state_nxt = ST_GAP;
      ST_GAP:   if (tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Half-period divider: reloads on every expiry, which is exactly when a
  // state change or SCLK toggle happens; parked at reload while idle.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN)                          div_cnt <= DIV_RELOAD;
    else if ((state == ST_IDLE) || tick) div_cnt <= DIV_RELOAD;
    else                                 div_cnt <= div_cnt - 1'b1;
  end

  // Serial datapath: SCLK generation, rising-edge count, SDO advance on falls.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      SCLK    <= 1'b0;
      SDO     <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            SDO     <= sel_data[DATA_W-1];
            shreg   <= sel_data[DATA_W-2:0];
            bit_cnt <= '0;
          end
          SCLK <= 1'b0;
        end
        ST_SETUP: begin
          if (tick) begin
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (SCLK) begin
              SCLK <= 1'b0;
              // The fall after the final rise keeps the LSB on the line.
              if (bit_cnt != BIT_LAST) begin
                SDO   <= shreg[DATA_W-2];
                shreg <= shreg << 1;
              end
            end else if (bit_cnt != BIT_LAST) begin
              SCLK    <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) SDO <= 1'b0;
        end
        default: begin
          SCLK <= 1'b0;
        end
      endcase
    end
  end

  // Control outputs: grant pulses, chip select, busy, done, round-robin pointer.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      CS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rr_next <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            gnt0    <= !win1;
            gnt1    <= win1;
            rr_next <= !win1;
            CS      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            CS   <= 1'b1;
            done <= 1'b1;
          end
        end
        ST_GAP: begin
          if (tick) busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: two instances (H=2 and H=1) each with a transaction-level
// arbiter model feeding an expectation queue, and a monitor checking each frame.
module tb_spi_arb;

  localparam int DW = 16;

  typedef struct {
    bit            who;
    logic [DW-1:0] data;
    bit            b2b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int DP      = (g == 0) ? 1 : 0;
    localparam int H       = 1 << DP;
    localparam int LOW_LEN = (2 * DW + 2) * H;
    localparam int PERIOD  = (2 * DW + 3) * H + 1;

    logic          rst, en, r0, r1;
    logic [DW-1:0] d0, d1;
    logic          gnt0, gnt1, busy, done, CS, SCLK, SDO;
    bit            fin = 1'b0;

    spi_arb #(.DATA_W(DW), .DIV_POW(DP)) dut (
      .CLK_IN(clk), .RST_IN(rst), .enable(en),
      .req0(r0), .req1(r1), .data0(d0), .data1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
      .CS(CS), .SCLK(SCLK), .SDO(SDO)
    );

    task automatic lchk(input string name, input logic [63:0] act, input logic [63:0] req);
      chk($sformatf("L%0d %s", g, name), act, req);
    endtask

    // ---------------- reference model ----------------
    exp_t q[$];
    int   cyc_n = 0;
    int   free_at = 0;
    int   last_g = 0;
    bit   rr = 1'b0;
    bit   have_prev = 1'b0;

    initial begin
      exp_t e;
      bit   w;
      forever begin
        @(posedge clk);
        cyc_n++;
        if (rst) begin
          rr        = 1'b0;
          free_at   = cyc_n + 1;
          have_prev = 1'b0;
        end else if (cyc_n >= free_at && en && (r0 || r1)) begin
          w      = (r0 && r1) ? rr : r1;
          e.who  = w;
          e.data = w ? d1 : d0;
          e.b2b  = have_prev && (cyc_n == last_g + PERIOD);
          q.push_back(e);
          rr        = !w;
          last_g    = cyc_n;
          have_prev = 1'b1;
          free_at   = cyc_n + PERIOD;
        end
      end
    end

    // ---------------- monitor ----------------
    initial begin
      exp_t          cur;
      int            k, hi_cnt, rises, wave_err, idx;
      bit            in_frame, prev_sclk, exp_sclk;
      logic [DW-1:0] word;
      cur.who = 1'b0; cur.data = '0; cur.b2b = 1'b0;
      k = 0; rises = 0; wave_err = 0; word = '0;
      in_frame = 1'b0; hi_cnt = 1000; prev_sclk = 1'b0;
      forever begin
        @(posedge clk);
        #2;
        if (rst) begin
          lchk("reset outputs", 64'({CS, SCLK, SDO, gnt0, gnt1, busy, done}), 64'(7'b1000000));
          in_frame  = 1'b0;
          hi_cnt    = 1000;
          prev_sclk = 1'b0;
          continue;
        end
        if (!in_frame && !CS) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL L%0d frame start: actual unexpected frame required no frame", g);
            cur.who = 1'b0; cur.data = '0; cur.b2b = 1'b0;
          end else begin
            cur = q.pop_front();
          end
          lchk("grant owner", 64'({gnt1, gnt0}), cur.who ? 64'(2'b10) : 64'(2'b01));
          if (cur.b2b) lchk("cs high gap", 64'(hi_cnt), 64'(H + 1));
          in_frame = 1'b1;
          k = 0; word = '0; rises = 0; wave_err = 0;
        end
        if (in_frame) begin
          if (!CS) begin
            if (k < H + 2 * DW * H) begin
              exp_sclk = (k >= H) && ((((k - H) / H) % 2) == 0);
              idx = k / (2 * H);
              if (idx > DW - 1) idx = DW - 1;
              if (SCLK !== exp_sclk || SDO !== cur.data[DW-1-idx]) wave_err++;
            end else if (SCLK !== 1'b0) begin
              wave_err++;
            end
            if (k > 0 && (gnt0 || gnt1)) wave_err++;
            if (done || !busy) wave_err++;
            if (SCLK && !prev_sclk) begin
              word = {word[DW-2:0], SDO};
              rises++;
            end
            k++;
          end else begin
            lchk("cs low length", 64'(k), 64'(LOW_LEN));
            lchk("serial word", 64'(word), 64'(cur.data));
            lchk("sclk rises", 64'(rises), 64'(DW));
            lchk("waveform errors", 64'(wave_err), 64'(0));
            lchk("frame end outputs", 64'({done, busy, SCLK, SDO}), 64'(4'b1100));
            in_frame = 1'b0;
            hi_cnt   = 1;
          end
        end else begin
          hi_cnt++;
          lchk("idle outputs", 64'({SCLK, SDO, done, gnt0, gnt1, busy}),
               64'({5'b00000, (hi_cnt <= H)}));
        end
        prev_sclk = SCLK;
      end
    end

    // ---------------- stimulus ----------------
    task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input bit who);
      bit ok = 1'b0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
        @(negedge clk);
        if (who ? gnt1 : gnt0) begin
          ok = 1'b1;
          break;
        end
      end
      lchk("grant seen in time", 64'(ok), 64'(1));
    endtask

    task automatic wait_any_gnt(output bit who);
      bit ok = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
        @(negedge clk);
        if (gnt0 || gnt1) begin
          ok  = 1'b1;
          who = gnt1;
          break;
        end
      end
      lchk("any grant seen in time", 64'(ok), 64'(1));
    endtask

    task automatic wait_quiet();
      bit ok = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
        @(negedge clk);
        if (!busy && CS && q.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      lchk("returned to idle in time", 64'(ok), 64'(1));
    endtask

    initial begin
      logic [3:0] seq;
      bit         who;
      int         cnt, rises;
      bit         prev, ok;

      rst = 1'b1; en = 1'b1; r0 = 1'b0; r1 = 1'b0; d0 = '0; d1 = '0;
      tick_n(3);
      rst = 1'b0;

      // single frame; data changes one cycle after the grant
      d0 = 16'hA5C3; r0 = 1'b1;
      wait_gnt(1'b0);
      r0 = 1'b0;
      tick_n(1);
      d0 = '0;
      wait_quiet();

      // contention from reset: expect 0,1,0,1
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0; r0 = 1'b1; r1 = 1'b1; d0 = DW'($urandom); d1 = DW'($urandom);
      seq = '0;
      for (int n = 0; n < 4; n++) begin
        wait_any_gnt(who);
        seq[n] = who;
        if (who) d1 = DW'($urandom);
        else     d0 = DW'($urandom);
      end
      r0 = 1'b0; r1 = 1'b0;
      lchk("contention order", 64'(seq), 64'(4'b1010));
      wait_quiet();

      // enable gating
      en = 1'b0; r1 = 1'b1; d1 = DW'($urandom);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (!CS || gnt0 || gnt1) cnt++;
      end
      lchk("no grant while disabled", 64'(cnt), 64'(0));
      en = 1'b1;
      @(posedge clk);
      #2;
      lchk("grant on edge after enable", 64'({gnt1, gnt0, CS}), 64'(3'b100));
      @(negedge clk);
      r1 = 1'b0; r0 = 1'b1; d0 = DW'($urandom);
      tick_n(10);
      en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
        @(negedge clk);
        if (CS) begin
          ok = 1'b1;
          break;
        end
      end
      lchk("frame completes after enable drop", 64'(ok), 64'(1));
      cnt = 0;
      for (int i = 0; i < PERIOD + 10; i++) begin
        @(negedge clk);
        if (!CS || gnt0 || gnt1) cnt++;
      end
      lchk("no grant after enable drop", 64'(cnt), 64'(0));
      r0 = 1'b0; en = 1'b1;
      wait_quiet();

      // reset in the middle of a frame
      d0 = DW'($urandom); r0 = 1'b1;
      wait_gnt(1'b0);
      r0 = 1'b0;
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
        @(negedge clk);
        if (SCLK && !prev) rises++;
        prev = SCLK;
        if (rises == 7) break;
      end
      lchk("seventh sclk rise reached", 64'(rises), 64'(7));
      rst = 1'b1;
      @(posedge clk);
      #2;
      lchk("mid-frame reset outputs", 64'({CS, SCLK, SDO, busy, done}), 64'(5'b10000));
      @(negedge clk);
      rst = 1'b0; r0 = 1'b1; r1 = 1'b1; d0 = DW'($urandom); d1 = DW'($urandom);
      @(posedge clk);
      #2;
      lchk("first grant after reset", 64'({gnt1, gnt0}), 64'(2'b01));
      @(negedge clk);
      r0 = 1'b0;
      wait_gnt(1'b1);
      r1 = 1'b0;
      wait_quiet();

      // randomized traffic
      en = 1'b1;
      for (int c = 0; c < 2500; c++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 99) == 0) en = !en;
        if (gnt0) begin
          if ($urandom_range(0, 1) == 1) d0 = DW'($urandom);
          else                           r0 = 1'b0;
        end else if (!r0) begin
          if ($urandom_range(0, 7) == 0) begin
            r0 = 1'b1;
            d0 = DW'($urandom);
          end
        end else begin
          if ($urandom_range(0, 39) == 0)     r0 = 1'b0;
          else if ($urandom_range(0, 9) == 0) d0 = DW'($urandom);
        end
        if (gnt1) begin
          if ($urandom_range(0, 1) == 1) d1 = DW'($urandom);
          else                           r1 = 1'b0;
        end else if (!r1) begin
          if ($urandom_range(0, 7) == 0) begin
            r1 = 1'b1;
            d1 = DW'($urandom);
          end
        end else begin
          if ($urandom_range(0, 39) == 0)     r1 = 1'b0;
          else if ($urandom_range(0, 9) == 0) d1 = DW'($urandom);
        end
      end
      rst = 1'b0; r0 = 1'b0; r1 = 1'b0; en = 1'b1;
      wait_quiet();
      fin = 1'b1;
    end
  end

  initial begin
    int waited = 0;
    while (!(lane[0].fin && lane[1].fin) && waited < 30000) begin
      @(negedge clk);
      waited++;
    end
    chk("both lanes completed", 64'({lane[1].fin, lane[0].fin}), 64'(2'b11));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
